// File: rtl/alu_result_if.sv
// Handshake bundle between the ALU, the result stage and writeback.
// The master side is the surrounding environment; the slave side is the stage.
interface alu_result_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_op;
  logic [DATA_WIDTH-1:0] in_result;
  logic                  in_is_zero;
  logic [TAG_WIDTH-1:0]  in_tag;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_result;
  logic                  out_is_zero;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  out_illegal;

  modport master (
    output in_valid, in_op, in_result, in_is_zero, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_is_zero, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_result, in_is_zero, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_is_zero, out_tag, out_illegal
  );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: in-order circular buffer of ALU results with
// architectural zero flag tracking and screening of undefined opcodes 10-15.
module alu_result_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int DEPTH      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  alu_result_if.slave             bus,
  output logic                    flag_zero,
  output logic [7:0]              illegal_count,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT      = CNT_W'(DEPTH);
  localparam logic [3:0]       LAST_LEGAL_OP = 4'd9;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

  logic [DATA_WIDTH-1:0] res_q  [DEPTH];
  logic [DATA_WIDTH-1:0] res_d  [DEPTH];
  logic                  zero_q [DEPTH];
  logic                  zero_d [DEPTH];
  logic [TAG_WIDTH-1:0]  tag_q  [DEPTH];
  logic [TAG_WIDTH-1:0]  tag_d  [DEPTH];
  logic                  ill_q  [DEPTH];
  logic                  ill_d  [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  flag_zero_q, flag_zero_d;
  logic [7:0]            ill_cnt_q, ill_cnt_d;

  logic [DATA_WIDTH-1:0] head_res_q, head_res_d;
  logic                  head_zero_q, head_zero_d;
  logic [TAG_WIDTH-1:0]  head_tag_q, head_tag_d;
  logic                  head_ill_q, head_ill_d;

  logic                  in_ready_c;
  logic                  out_valid_c;
  logic                  push;
  logic                  pop;
  logic                  op_illegal;

  // in_ready looks through to out_ready so a full buffer can swap head for tail.
  always_comb begin
    in_ready_c  = (count_q < FULL_CNT) || bus.out_ready;
    out_valid_c = (count_q != '0);
    push        = bus.in_valid && in_ready_c;
    pop         = out_valid_c && bus.out_ready;
    op_illegal  = (bus.in_op > LAST_LEGAL_OP);
  end

  always_comb begin
    res_d       = res_q;
    zero_d      = zero_q;
    tag_d       = tag_q;
    ill_d       = ill_q;
    wr_ptr_d    = wr_ptr_q;
    flag_zero_d = flag_zero_q;
    ill_cnt_d   = ill_cnt_q;
    if (push) begin
      res_d[wr_ptr_q]  = op_illegal ? '0 : bus.in_result;
      zero_d[wr_ptr_q] = op_illegal ? 1'b0 : bus.in_is_zero;
      tag_d[wr_ptr_q]  = bus.in_tag;
      ill_d[wr_ptr_q]  = op_illegal;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
      // The flag follows acceptance order, never drain order.
      if (op_illegal) begin
        ill_cnt_d = sat_inc8(ill_cnt_q);
      end else begin
        flag_zero_d = bus.in_is_zero;
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Head registers preload the next head entry; they hold when the buffer drains.
  always_comb begin
    head_res_d  = head_res_q;
    head_zero_d = head_zero_q;
    head_tag_d  = head_tag_q;
    head_ill_d  = head_ill_q;
    if (count_d != '0) begin
      head_res_d  = res_d[rd_ptr_d];
      head_zero_d = zero_d[rd_ptr_d];
      head_tag_d  = tag_d[rd_ptr_d];
      head_ill_d  = ill_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        res_q[i]  <= '0;
        zero_q[i] <= 1'b0;
        tag_q[i]  <= '0;
        ill_q[i]  <= 1'b0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      flag_zero_q <= 1'b0;
      ill_cnt_q   <= 8'd0;
      head_res_q  <= '0;
      head_zero_q <= 1'b0;
      head_tag_q  <= '0;
      head_ill_q  <= 1'b0;
    end else begin
      res_q       <= res_d;
      zero_q      <= zero_d;
      tag_q       <= tag_d;
      ill_q       <= ill_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      flag_zero_q <= flag_zero_d;
      ill_cnt_q   <= ill_cnt_d;
      head_res_q  <= head_res_d;
      head_zero_q <= head_zero_d;
      head_tag_q  <= head_tag_d;
      head_ill_q  <= head_ill_d;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.out_result  = head_res_q;
  assign bus.out_is_zero = head_zero_q;
  assign bus.out_tag     = head_tag_q;
  assign bus.out_illegal = head_ill_q;
  assign flag_zero       = flag_zero_q;
  assign illegal_count   = ill_cnt_q;
  assign count           = count_q;

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage directly downstream of the combinational ALU. Captures each ALU result (`out`, `is_zero`) with its opcode and destination tag under a valid/ready handshake, buffers up to DEPTH results in order, and presents them to writeback. Maintains the architectural zero flag and screens opcodes 10–15, for which the ALU defines no result.

## Interface
Parameters:
- `DATA_WIDTH`, 32, result width; must match the ALU.
- `TAG_WIDTH`, 4, destination-register tag width.
- `DEPTH`, 2, result buffer entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream presents a result.
- `in_ready`  out  1  stage can accept this cycle.
- `in_op`  in  4  opcode driving the ALU this cycle.
- `in_result`  in  DATA_WIDTH  ALU `out`.
- `in_is_zero`  in  1  ALU `is_zero`.
- `in_tag`  in  TAG_WIDTH  destination tag.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  writeback consumes the head.
- `out_result`  out  DATA_WIDTH  head result.
- `out_is_zero`  out  1  head zero indication.
- `out_tag`  out  TAG_WIDTH  head tag.
- `out_illegal`  out  1  head came from an illegal opcode.
- `flag_zero`  out  1  architectural zero flag.
- `illegal_count`  out  8  saturating count of illegal opcodes accepted.
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Push: `in_valid && in_ready`. Pop: `out_valid && out_ready`.
- `in_ready = (count < DEPTH) || out_ready`. Push and pop in the same cycle are allowed when full. `in_ready` has a combinational path from `out_ready`.
- Legal opcode (0–9): the entry stores `in_result`, `in_is_zero`, `in_tag`, and `illegal = 0`. On the same edge, `flag_zero <= in_is_zero`.
- Illegal opcode (10–15): the entry stores result 0, `is_zero = 0`, `in_tag`, and `illegal = 1`.
  - `flag_zero` is unchanged.
  - `illegal_count` increments, saturating at 255.
- The flag updates at acceptance, not at drain. Program order of flag updates equals push order.
- Storage is a circular buffer with write and read pointers that wrap modulo DEPTH.
- `count` changes as follows:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- Output ports are driven from the head entry's registers. When `out_valid = 0`, the outputs hold their last value. Testbenches must not check them in that state.
- A push while `in_valid = 1` and `in_ready = 0` does not occur: the stage ignores the inputs.
- Upstream must hold the inputs stable until the transfer completes.

## Timing
- Reset (`rst_n` low, asynchronous): `count = 0`, `out_valid = 0`, `in_ready = 1`, `flag_zero = 0`, `illegal_count = 0`, pointers = 0, `out_*` data = 0.
  - Reset mid-operation discards all buffered entries immediately.
  - Release is sampled at the next rising edge.
- Latency: a push at edge N into an empty stage gives `out_valid = 1` after edge N, with the data visible in cycle N+1. There is no bypass, so empty-in to out is never zero-cycle.
- Throughput: one result per cycle sustained when `out_ready` stays high.
- Full with `out_ready = 0`: `in_ready = 0` and state holds.
- Empty with a pop attempt: no effect, because `out_valid = 0`.
- Pointer wrap: entry order is preserved across the DEPTH−1 → 0 wrap.

## Test plan
- Reset: assert `rst_n = 0` mid-stream with 2 entries held → `count = 0`, `out_valid = 0`, `flag_zero = 0`, `illegal_count = 0` immediately, without waiting for an edge.
- Single legal op: `op = 1`, result 0, `is_zero = 1`, tag 5, `out_ready = 1` → one cycle later `out_valid = 1`, `out_result = 0`, `out_tag = 5`, `out_is_zero = 1`, and `flag_zero = 1` after the push edge.
- Backpressure: hold `out_ready = 0` and push 3 results (tags 1, 2, 3) → tags 1 and 2 accepted, `in_ready = 0` on the third, `count = 2`. Release → drains 1, 2, then 3 accepted, in order.
- Full push+pop: with the buffer full, `out_ready = 1` and a push of tag 7 → head pops, tag 7 is accepted in the same cycle, and `count` stays at 2.
- Illegal op: after a legal `is_zero = 1` op, push `op = 4'b1100` with result 0x1234 → entry shows `out_result = 0`, `out_illegal = 1`, `flag_zero` stays 1, `illegal_count = 1`. Push 300 illegal ops → `illegal_count = 255`.
- Wrap stress: 1000 random pushes and pops with a scoreboard → outputs match in order across pointer wrap, and `flag_zero` tracks the last legal `is_zero`.
